// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART transmit path.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and show-ahead read data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with configurable frame format and a transmit FIFO.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          uart_tx
);

    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);

    tx_state_e            state, state_next;
    logic [CNT_W-1:0]     baud_cnt, baud_next;
    logic [2:0]           bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next, fifo_data;
    logic                 par_acc, par_next;
    logic                 pop, tick, tx_d, busy_d;

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (pop),
        .rd_data(fifo_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign tick = (baud_cnt == CNT_W'(CPB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            par_acc  <= par_next;
            uart_tx  <= tx_d;
            busy     <= busy_d;
            overflow <= overflow | (wr_en & full);
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + CNT_W'(1);
        bit_next   = bit_cnt;
        shift_next = shift;
        par_next   = par_acc;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                    shift_next = fifo_data;
                    par_next   = 1'b0;
                    bit_next   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    baud_next  = '0;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_next  = '0;
                    par_next   = par_acc ^ shift[0];
                    shift_next = shift >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_next = '0;
                        if (PARITY != PAR_NONE)
                            state_next = ST_PARITY;
                        else
                            state_next = ST_STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    baud_next  = '0;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    baud_next = '0;
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_next = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = ST_START;
                            shift_next = fifo_data;
                            par_next   = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so the output flop switches with the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_next[0];
            ST_PARITY: tx_d = (PARITY == PAR_ODD) ? ~par_next : par_next;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_next != ST_IDLE);
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an integrated transmit FIFO, the successor to the fixed 8N1 transmitter behind `uart_tx` in `cpu_top`. Configurable character width, parity, stop bits and buffer depth, so the CPU's store path can queue several characters without stalling. Sits between the CPU's memory-mapped UART register and the `uart_tx` pin.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: core clock frequency.
- `BAUD`, default 115_200: line rate. `CLKS_PER_BIT = CLK_HZ / BAUD` (floor); must be ≥ 2.
- `DATA_BITS`, default 8: character width, legal 5–8.
- `PARITY`, default 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `FIFO_DEPTH`, default 16: power of two, ≥ 2.

**Ports**
- `clk` input, 1: the single clock.
- `rst` input, 1: synchronous, active-high reset.
- `wr_en` input, 1: push request.
- `wr_data` input, DATA_BITS: character to queue.
- `full` output, 1: FIFO holds FIFO_DEPTH entries.
- `empty` output, 1: FIFO holds 0 entries.
- `count` output, $clog2(FIFO_DEPTH)+1: current occupancy.
- `busy` output, 1: a frame is on the line.
- `overflow` output, 1: sticky; a write was dropped.
- `uart_tx` output, 1: serial line, idle high.

## Operation

- Reset values: `uart_tx`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0. FIFO pointers cleared, FSM in IDLE, baud counter 0.
- Push: `wr_en && !full` (full as registered at the edge) writes `wr_data`. `wr_en && full` drops the data and sets `overflow`, which is cleared only by `rst`.
- Simultaneous push and pop on a non-full FIFO: both happen, and `count` is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if `!empty`, pop the head into the shift register, go to START, and set `busy`.
- START: line 0.
- DATA: DATA_BITS bits, LSB first.
- PARITY: entered only when PARITY≠0. Odd parity: total ones (data plus parity) is odd. Even parity: total ones is even.
- STOP: line 1 for STOP_BITS bit periods.
- Every bit period lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at each state entry.
- End of last stop period with FIFO non-empty: pop and enter START directly, with no idle gap and `busy` held high.
- End of last stop period with FIFO empty: go to IDLE and clear `busy`.
- Reset mid-frame: `uart_tx` returns to 1 on the next edge, the FIFO is flushed, and the partial frame is abandoned.
- `wr_data` bits above DATA_BITS do not exist. No runtime configuration.

## Timing

- Write at edge N:
  - `empty`=0 and `count`=1 after edge N.
  - FSM pops at edge N+1.
  - `uart_tx` falls after edge N+1, two edges after the write.
- Frame length: CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- `full`, `empty`, `count` are registered and update on the edge after the push or pop.
- `busy` rises with the START entry and falls on the edge where the FSM enters IDLE.
- `uart_tx` is driven from a flop (glitch-free).

## Structure

- Package `uart_pkg` holds:
  - parity mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the FSM state encoding;
  - the `CLKS_PER_BIT` derivation function.
- Sub-module `sync_fifo`: parametrised width and depth, with `full`/`empty`/`count` and a synchronous active-high `rst`. Reusable for a future RX path.
- Top level contains the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan

All scenarios use CLK_HZ=1_000_000 and BAUD=100_000, giving 10 clocks/bit.

- **8N1, write 0x55:**
  - `uart_tx` is low for 10 cycles starting 2 edges after the write.
  - Then 1,0,1,0,1,0,1,0, each 10 cycles.
  - Then high 10 cycles.
  - `busy` is high for exactly 100 cycles.
- **8E1, write 0x07:** parity bit is 1; frame is 110 cycles. With 8O1 the parity bit is 0.
- **7N2, write 0x41:** data is seven bits 1,0,0,0,0,0,1, then 20 cycles high; frame is 100 cycles.
- **Back-to-back, FIFO_DEPTH=4:** write 0xA5 then 0x3C on consecutive cycles. The second start bit begins on the cycle immediately after the first frame's 100th cycle. `busy` never drops between frames.
- **Overflow, FIFO_DEPTH=4:** write 0x01–0x06 on six consecutive cycles.
  - `count` sequence is 1,1,2,3,4.
  - The 6th write is dropped and `overflow`=1 persists.
  - Exactly 5 frames (0x01–0x05) appear.
- **Reset mid-frame:** assert `rst` for 1 cycle during the data bits of the 0x55 frame. Next edge: `uart_tx`=1, `count`=0, `busy`=0, `overflow`=0. No further frames are sent.
